ad1xx_lsu: RTL
==============

# ad1xx_lsu

Parametrised load/store unit for the ad1xx core family. It sits between the execute stage and the data memory port. It accepts one load or store per handshake, drives byte-enabled memory beats, and returns sign- or zero-extended load data. It generalises the fixed 32-bit byte/half/word path to XLEN=32/64 and adds misaligned-access splitting, memory wait states and a fault response.

## Interface

- XLEN, 32: data width, 32 or 64
- ADDR_W, 32: byte-address width
- ALLOW_MISALIGNED, 1: 1 = split boundary-crossing accesses into two beats; 0 = fault them
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  CPU request valid
- req_ready  out  1  LSU can accept (high only in IDLE)
- req_we  in  1  1 = store
- req_size  in  2  0 byte, 1 half, 2 word, 3 double (legal only when XLEN=64)
- req_unsigned  in  1  zero-extend the load (LBU/LHU/LWU)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, LSB-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  XLEN  extended load data; 0 for stores and faults
- rsp_fault  out  1  qualifies rsp_valid
- mem_valid  out  1  memory beat valid
- mem_ready  in  1  memory accepts or completes the beat
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_W  XLEN/8-aligned beat address
- mem_be  out  XLEN/8  byte enables
- mem_wdata  out  XLEN  lane-shifted write data
- mem_rdata  in  XLEN  read data, valid with mem_ready

## Operation

- B = XLEN/8. off = req_addr mod B. n = 1<<req_size. cross = (off+n > B).
- Fault if req_size=3 and XLEN=32, or if cross and ALLOW_MISALIGNED=0. No memory beat is issued.
- Beat 1 signals:
  - mem_addr = addr with the low bits cleared.
  - mem_be = ((1<<n)-1)<<off, truncated to B bits.
  - mem_wdata = wdata << 8*off.
- Beat 2 (cross only) signals:
  - mem_addr = beat-1 address + B, wrapping modulo 2^ADDR_W.
  - mem_be = ((1<<n)-1) >> (B-off).
  - mem_wdata = wdata >> 8*(B-off).
- Load assembly: (rdata1 >> 8*off) | (rdata2 << 8*(B-off)). Keep the low n bytes. Sign-extend from bit 8n-1 unless req_unsigned.
- Request fields are captured on acceptance. Input changes afterwards are ignored.
- FSM states:
  - IDLE: on accept, go to RESP if fault, else to BEAT1.
  - BEAT1: on mem_ready, go to BEAT2 if cross, else to RESP.
  - BEAT2: on mem_ready, go to RESP.
  - RESP: go to IDLE.
- Loads with mem_we=0 still drive mem_be (the memory may ignore it).

## Timing

- Reset values: req_ready=1, rsp_valid=0, rsp_fault=0, rsp_rdata=0, mem_valid=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0. The state is IDLE.
- Aligned access accepted at edge N:
  - mem_valid is high from cycle N+1.
  - With mem_ready=1, rsp_valid is high in cycle N+2.
  - req_ready returns high in cycle N+3.
- A split access adds one cycle per beat. A fault gives rsp_valid in cycle N+1.
- Each cycle with mem_ready=0 adds one cycle.
- mem_* outputs stay stable while mem_valid=1 and mem_ready=0. A beat is never withdrawn except by reset.
- Reset mid-operation: mem_valid and rsp_valid drop asynchronously. The FSM goes to IDLE and the pending response is lost.
- rsp_valid is never high at the same time as req_ready.

## Structure

- Put these in shared package ad1xx_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D
  - the lsu_state_t enum
- Sub-module ad1xx_lane_align is combinational. It handles the be/wdata shift and the load merge plus extension.
- The FSM and capture registers live in ad1xx_lsu.

## Test plan

Test setup: XLEN=32. Memory word 0x0 = 0x12F4_8081, word 0x4 = 0xA5B6_C7D8. mem_ready=1 unless stated.

- Byte loads:
  - LB @0 returns 0xFFFF_FF81.
  - LBU @1 returns 0x0000_0080.
  - Each rsp_valid arrives 2 cycles after accept.
- Half loads:
  - LH @0 returns 0xFFFF_8081.
  - LHU @0 returns 0x0000_8081.
  - LH @2 returns 0x0000_12F4.
- Misaligned LW @3:
  - Beat 1 is addr 0x0, be 1000.
  - Beat 2 is addr 0x4, be 0111.
  - Returns 0xB6C7_D812 with rsp_valid 3 cycles after accept.
  - With ALLOW_MISALIGNED=0: fault at N+1 and no mem_valid.
- Stores:
  - SB 0x55 @1 drives be 0010, wdata 0x0000_5500.
  - SH 0xBEEF @3:
    - beat 1 is addr 0x0, be 1000, wdata 0xEF00_0000
    - beat 2 is addr 0x4, be 0001, wdata 0x0000_00BE
- Wait states and reset:
  - Hold mem_ready=0 for 5 cycles: mem_* stay stable and rsp is delayed by 5 cycles.
  - Pull rst_n low during BEAT2: mem_valid drops immediately, no rsp follows, and req_ready=1 after release.
- req_size=3 at XLEN=32: rsp_fault=1 and rdata=0 at N+1, with no memory beat.

Source files
------------

// File: rtl/ad1xx_pkg.sv
// Shared definitions for the ad1xx load/store unit: access-size codes, FSM states
// and the size-to-byte-count helper.
package ad1xx_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT1 = 2'd1,
    ST_BEAT2 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/ad1xx_lsu_if.sv
// CPU request/response and data-memory beat signals of the load/store unit.
// slave is the LSU view; master is the CPU plus memory environment.
interface ad1xx_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_fault;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
    output mem_valid, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
    input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/ad1xx_lane_align.sv
// Combinational byte-lane steering: byte enables and write data for both beats,
// and the two-beat load merge with sign/zero extension.
module ad1xx_lane_align
  import ad1xx_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int B     = XLEN / 8,
  localparam int OFF_W = $clog2(B)
) (
  input  logic [OFF_W-1:0] i_off,
  input  logic [1:0]       i_size,
  input  logic             i_unsigned,
  input  logic [XLEN-1:0]  i_wdata,
  input  logic [XLEN-1:0]  i_rdata1,
  input  logic [XLEN-1:0]  i_rdata2,
  output logic             o_cross,
  output logic [B-1:0]     o_be1,
  output logic [B-1:0]     o_be2,
  output logic [XLEN-1:0]  o_wdata1,
  output logic [XLEN-1:0]  o_wdata2,
  output logic [XLEN-1:0]  o_rdata
);
  logic [3:0]        w_nbytes;
  logic [B-1:0]      w_nmask;
  logic [2*B-1:0]    w_mask;
  logic [2*XLEN-1:0] w_wide_wdata;
  logic [XLEN-1:0]   w_merged;
  logic              w_sign;

  assign w_nbytes = size_bytes(i_size);
  assign o_cross  = (int'(i_off) + int'(w_nbytes)) > B;

  // Unshifted enable mask: one bit per accessed byte, saturating at the full bus.
  always_comb begin
    w_nmask = '0;
    for (int i = 0; i < B; i++) begin
      if (i < int'(w_nbytes)) w_nmask[i] = 1'b1;
      else                    w_nmask[i] = 1'b0;
    end
  end

  // Double-width shifts: the low half is beat 1, the spill-over high half is beat 2.
  assign w_mask       = {{B{1'b0}}, w_nmask} << i_off;
  assign o_be1        = w_mask[B-1:0];
  assign o_be2        = w_mask[2*B-1:B];
  assign w_wide_wdata = {{XLEN{1'b0}}, i_wdata} << {i_off, 3'b000};
  assign o_wdata1     = w_wide_wdata[XLEN-1:0];
  assign o_wdata2     = w_wide_wdata[2*XLEN-1:XLEN];
  assign w_merged     = XLEN'({i_rdata2, i_rdata1} >> {i_off, 3'b000});

  // Keep the low n bytes, then replicate the last kept bit unless zero-extending.
  always_comb begin
    w_sign  = 1'b0;
    o_rdata = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (i < 8 * int'(w_nbytes)) begin
        o_rdata[i] = w_merged[i];
        w_sign     = w_merged[i];
      end else begin
        o_rdata[i] = w_sign & ~i_unsigned;
      end
    end
  end
endmodule

// File: rtl/ad1xx_lsu.sv
// Load/store unit: accepts one request, issues one or two byte-enabled memory
// beats (or faults), and returns the extended load data as a one-cycle pulse.
module ad1xx_lsu
  import ad1xx_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  ad1xx_lsu_if.slave bus
);
  localparam int B     = XLEN / 8;
  localparam int OFF_W = $clog2(B);

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  logic              r_req_ready;
  logic              r_we;
  logic              r_unsigned;
  logic              r_cross;
  logic [1:0]        r_size;
  logic [OFF_W-1:0]  r_off;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_rdata1;
  logic              r_mem_valid;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [B-1:0]      r_mem_be;
  logic [XLEN-1:0]   r_mem_wdata;
  logic              r_rsp_valid;
  logic              r_rsp_fault;
  logic [XLEN-1:0]   r_rsp_rdata;

  logic              w_idle;
  logic              w_beat2;
  logic [OFF_W-1:0]  w_off;
  logic [1:0]        w_size;
  logic              w_unsigned;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_rd1;
  logic [XLEN-1:0]   w_rd2;
  logic              w_cross;
  logic              w_fault;
  logic [B-1:0]      w_be1;
  logic [B-1:0]      w_be2;
  logic [XLEN-1:0]   w_wdata1;
  logic [XLEN-1:0]   w_wdata2;
  logic [XLEN-1:0]   w_rdata;
  logic [ADDR_W-1:0] w_base;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_beat2 = (r_state == ST_BEAT2);

  // The aligner sees the live request only while idle; after that, the captured copy.
  assign w_off      = w_idle ? bus.req_addr[OFF_W-1:0] : r_off;
  assign w_size     = w_idle ? bus.req_size            : r_size;
  assign w_unsigned = w_idle ? bus.req_unsigned        : r_unsigned;
  assign w_wdata    = w_idle ? bus.req_wdata           : r_wdata;
  assign w_rd1      = w_beat2 ? r_rdata1 : bus.mem_rdata;
  assign w_rd2      = w_beat2 ? bus.mem_rdata : {XLEN{1'b0}};
  assign w_base     = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_fault    = ((bus.req_size == SZ_D) && (XLEN != 64)) ||
                      (w_cross && !ALLOW_MISALIGNED);

  ad1xx_lane_align #(.XLEN(XLEN)) u_align (
    .i_off      (w_off),
    .i_size     (w_size),
    .i_unsigned (w_unsigned),
    .i_wdata    (w_wdata),
    .i_rdata1   (w_rd1),
    .i_rdata2   (w_rd2),
    .o_cross    (w_cross),
    .o_be1      (w_be1),
    .o_be2      (w_be2),
    .o_wdata1   (w_wdata1),
    .o_wdata2   (w_wdata2),
    .o_rdata    (w_rdata)
  );

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) w_next = w_fault ? ST_RESP : ST_BEAT1;
        else               w_next = ST_IDLE;
      end
      ST_BEAT1: begin
        if (bus.mem_ready) w_next = r_cross ? ST_BEAT2 : ST_RESP;
        else               w_next = ST_BEAT1;
      end
      ST_BEAT2: begin
        if (bus.mem_ready) w_next = ST_RESP;
        else               w_next = ST_BEAT2;
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Request capture, memory-beat and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b1;
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_cross     <= 1'b0;
      r_size      <= 2'd0;
      r_off       <= '0;
      r_wdata     <= '0;
      r_rdata1    <= '0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_req_ready <= (w_next == ST_IDLE);
      r_mem_valid <= (w_next == ST_BEAT1) || (w_next == ST_BEAT2);
      r_rsp_valid <= (w_next == ST_RESP);
      r_rsp_fault <= w_idle && (w_next == ST_RESP);
      r_rsp_rdata <= (!w_idle && (w_next == ST_RESP) && !r_we) ? w_rdata : {XLEN{1'b0}};
      if (w_idle && bus.req_valid) begin
        r_we       <= bus.req_we;
        r_unsigned <= bus.req_unsigned;
        r_cross    <= w_cross;
        r_size     <= bus.req_size;
        r_off      <= bus.req_addr[OFF_W-1:0];
        r_wdata    <= bus.req_wdata;
        if (!w_fault) begin
          r_mem_we    <= bus.req_we;
          r_mem_addr  <= w_base;
          r_mem_be    <= w_be1;
          r_mem_wdata <= w_wdata1;
        end else begin
          r_mem_we <= 1'b0;
        end
      end else if ((r_state == ST_BEAT1) && bus.mem_ready && r_cross) begin
        r_rdata1    <= bus.mem_rdata;
        r_mem_addr  <= r_mem_addr + ADDR_W'(B);
        r_mem_be    <= w_be2;
        r_mem_wdata <= w_wdata2;
      end else begin
        r_rdata1 <= r_rdata1;
      end
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_fault = r_rsp_fault;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_wdata = r_mem_wdata;
endmodule
